// File: rtl/output_register.sv
// Holds a 2*WIDTH-bit product and drains it as a low word, then a high word,
// over a valid/ready handshake. Also flags loads that arrive while busy.
module output_register #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] in,
  input  logic               ld,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_hold;
  logic [2*WIDTH-1:0]   w_hold_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 r_overrun;
  logic                 w_overrun_next;
  logic                 w_xfer;

  // Valid is asserted in every non-idle state, so derive the transfer from state.
  assign w_xfer = (r_state != ST_IDLE) && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_done    <= w_done_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_done_next    = 1'b0;
    w_overrun_next = r_overrun;
    out            = '0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    busy           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (ld) begin
          w_hold_next  = in;
          w_state_next = ST_SEND_LO;
        end
      end

      ST_SEND_LO: begin
        out       = r_hold[WIDTH-1:0];
        out_valid = 1'b1;
        busy      = 1'b1;
        if (ld) begin
          w_overrun_next = 1'b1;
        end
        if (w_xfer) begin
          w_state_next = ST_SEND_HI;
        end
      end

      ST_SEND_HI: begin
        out       = r_hold[2*WIDTH-1:WIDTH];
        out_valid = 1'b1;
        out_last  = 1'b1;
        busy      = 1'b1;
        if (w_xfer) begin
          w_done_next = 1'b1;
          // A load coinciding with the final transfer starts the next product with no bubble.
          if (ld) begin
            w_hold_next  = in;
            w_state_next = ST_SEND_LO;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (ld) begin
          w_overrun_next = 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_output_register.sv
// Directed bench for output_register: stimulus pushes expected words to a
// scoreboard, a negedge monitor pops and compares each word as it transfers.
module tb_output_register;

  localparam int WIDTH = 16;

  logic               clk;
  logic               reset;
  logic [2*WIDTH-1:0] in;
  logic               ld;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               overrun;

  int n_pass  = 0;
  int n_total = 0;

  // Each entry is {last, word}.
  logic [WIDTH:0] sb_q[$];

  output_register #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .ld        (ld),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_product(input logic [2*WIDTH-1:0] p);
    sb_q.push_back({1'b0, p[WIDTH-1:0]});
    sb_q.push_back({1'b1, p[2*WIDTH-1:WIDTH]});
  endtask

  // Inputs change 1 time unit after posedge, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", {15'd0, out_last, out}, 32'hDEAD_DEAD);
      end else begin
        logic [WIDTH:0] e;
        e = sb_q.pop_front();
        chk("sb_word", {15'd0, out_last, out}, {15'd0, e});
        $display("xfer word=0x%04h last=%0b expected=0x%04h last=%0b", out, out_last, e[WIDTH-1:0], e[WIDTH]);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in        = '0;
    ld        = 1'b0;
    out_ready = 1'b0;
    #22;
    chk("rst_out",       {16'd0, out}, 32'd0);
    chk("rst_valid",     {31'd0, out_valid}, 32'd0);
    chk("rst_last",      {31'd0, out_last}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_done",      {31'd0, done}, 32'd0);
    chk("rst_overrun",   {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Scenario 1: plain load, consumer always ready.
    out_ready = 1'b1;
    ld = 1'b1;
    in = 32'h1234_5678;
    push_product(in);
    tick();
    ld = 1'b0;
    chk("s1_lo_word",  {16'd0, out}, 32'h5678);
    chk("s1_lo_last",  {31'd0, out_last}, 32'd0);
    chk("s1_lo_busy",  {31'd0, busy}, 32'd1);
    tick();
    chk("s1_hi_word",  {16'd0, out}, 32'h1234);
    chk("s1_hi_last",  {31'd0, out_last}, 32'd1);
    chk("s1_hi_done",  {31'd0, done}, 32'd0);
    tick();
    chk("s1_done",     {31'd0, done}, 32'd1);
    chk("s1_valid",    {31'd0, out_valid}, 32'd0);
    chk("s1_busy",     {31'd0, busy}, 32'd0);
    tick();
    chk("s1_done_pulse", {31'd0, done}, 32'd0);

    // Scenario 2: backpressure holds the low word stable.
    out_ready = 1'b0;
    ld = 1'b1;
    in = 32'h1234_5678;
    push_product(in);
    tick();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s2_hold_word",  {16'd0, out}, 32'h5678);
      chk("s2_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    chk("s2_lo_word", {16'd0, out}, 32'h5678);
    tick();
    chk("s2_hi_word", {16'd0, out}, 32'h1234);
    tick();
    chk("s2_done",    {31'd0, done}, 32'd1);
    chk("s2_valid",   {31'd0, out_valid}, 32'd0);
    tick();

    // Scenario 3: back-to-back load on the final transfer.
    ld = 1'b1;
    in = 32'hFFFF_0001;
    push_product(in);
    tick();
    ld = 1'b0;
    chk("s3_a_lo", {16'd0, out}, 32'h0001);
    tick();
    chk("s3_a_hi", {16'd0, out}, 32'hFFFF);
    ld = 1'b1;
    in = 32'h8000_7FFF;
    push_product(in);
    tick();
    ld = 1'b0;
    chk("s3_b_lo",      {16'd0, out}, 32'h7FFF);
    chk("s3_b_lo_done", {31'd0, done}, 32'd1);
    chk("s3_b_valid",   {31'd0, out_valid}, 32'd1);
    tick();
    chk("s3_b_hi",      {16'd0, out}, 32'h8000);
    chk("s3_b_hi_done", {31'd0, done}, 32'd0);
    tick();
    chk("s3_done",      {31'd0, done}, 32'd1);
    chk("s3_overrun",   {31'd0, overrun}, 32'd0);
    tick();

    // Scenario 4: load while busy is dropped and flagged.
    out_ready = 1'b0;
    ld = 1'b1;
    in = 32'hAAAA_5555;
    push_product(in);
    tick();
    in = 32'h1111_2222;
    tick();
    ld = 1'b0;
    chk("s4_overrun",    {31'd0, overrun}, 32'd1);
    chk("s4_hold_word",  {16'd0, out}, 32'h5555);
    tick();
    chk("s4_overrun_st", {31'd0, overrun}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("s4_hi_word",    {16'd0, out}, 32'hAAAA);
    tick();
    chk("s4_done",       {31'd0, done}, 32'd1);
    chk("s4_overrun_end", {31'd0, overrun}, 32'd1);
    tick();

    // Scenario 5: asynchronous reset while the high word is pending.
    ld = 1'b1;
    in = 32'hDEAD_BEEF;
    sb_q.push_back({1'b0, in[WIDTH-1:0]});
    tick();
    ld = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("s5_in_hi",   {31'd0, out_last}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("s5_valid",   {31'd0, out_valid}, 32'd0);
    chk("s5_busy",    {31'd0, busy}, 32'd0);
    chk("s5_overrun", {31'd0, overrun}, 32'd0);
    chk("s5_out",     {16'd0, out}, 32'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_post_done",  {31'd0, done}, 32'd0);
      chk("s5_post_valid", {31'd0, out_valid}, 32'd0);
      chk("s5_post_out",   {16'd0, out}, 32'd0);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/output_register.md
Name: output_register

Overview:
- Result-side counterpart of the multiplier's operand input register.
- Captures the full-width product from the Booth datapath on a load strobe.
- Drains the product as two WIDTH-bit words, low word then high word, over a valid/ready handshake to the downstream consumer.
- Sits between the multiplier core and the result bus; its `done` output tells the controller the result has left the block.

Parameters:
- WIDTH, 16, output word width; the product input is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  2*WIDTH  product from the multiplier datapath.
- ld  input  1  load strobe; captures `in` when accepted.
- out_ready  input  1  consumer can accept a word this cycle.
- out  output  WIDTH  current result word.
- out_valid  output  1  `out` holds a valid word.
- out_last  output  1  current word is the high (final) word.
- busy  output  1  a product is held and not yet fully drained.
- done  output  1  one-cycle pulse after the final word transfers.
- overrun  output  1  sticky flag; set when `ld` arrives while the block cannot accept it.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the hold register clears to 0.
  - out=0, out_valid=0, out_last=0, busy=0, done=0, overrun=0.
  - Reset asserted mid-transfer aborts the transfer immediately; no word or `done` is produced after release.
- States:
  - IDLE: out_valid=0, out=0, busy=0.
  - SEND_LO: out_valid=1, out=hold[WIDTH-1:0], out_last=0, busy=1.
  - SEND_HI: out_valid=1, out=hold[2W-1:W], out_last=1, busy=1.
- Transfer: a transfer occurs on a rising edge where out_valid=1 and out_ready=1.
  - `out`, out_valid and out_last stay stable while out_ready=0 (no retraction, no word change).
- Transitions:
  - IDLE with ld=1: capture `in` into hold, go to SEND_LO. The low word is valid the cycle after ld (latency 1).
  - IDLE with ld=0: stay in IDLE.
  - SEND_LO with a transfer: go to SEND_HI. Without a transfer: stay.
  - SEND_HI with a transfer and ld=0: go to IDLE; done=1 for the next cycle only.
  - SEND_HI with a transfer and ld=1: capture `in` and go directly to SEND_LO (back-to-back, no bubble); done=1 for the next cycle.
  - SEND_HI without a transfer: stay.
- Overrun:
  - ld=1 in SEND_LO, or in SEND_HI without a transfer, is ignored. The hold register is unchanged and overrun sets to 1.
  - overrun clears only on reset.
- done:
  - Registered; never asserted in the same cycle as out_valid for the word that caused it, unless a back-to-back load began.
  - Never asserted for an aborted (reset) transfer.
- Arithmetic: none. Words are straight slices of the captured product; no sign handling, since sign is owned by the multiplier.
- out_ready is ignored in IDLE.

Test Plan:
1. Reset, then ld with in=0x1234_5678 and out_ready held 1:
   - Cycle+1: out=0x5678, out_last=0.
   - Cycle+2: out=0x1234, out_last=1.
   - Cycle+3: done=1, out_valid=0, busy=0.
2. Backpressure: same load, out_ready=0 for 4 cycles then 1:
   - out stays 0x5678 with out_valid=1 for all 4 cycles.
   - Then the sequence proceeds as in scenario 1; no word is lost or duplicated.
3. Back-to-back loads:
   - Load 0xFFFF_0001.
   - Assert ld with in=0x8000_7FFF in the cycle the high word 0xFFFF transfers.
   - Next cycle: out=0x7FFF, done=1.
   - Then out=0x8000.
4. Overrun: load 0xAAAA_5555 with out_ready=0, then pulse ld with in=0x1111_2222:
   - overrun=1 and stays 1.
   - Drained words are 0x5555 then 0xAAAA.
5. Reset mid-operation: reset=0 asynchronously while in SEND_HI:
   - out_valid, busy and overrun drop to 0 without waiting for a clock edge.
   - After release the block idles with out=0 and produces no done pulse.
